// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the single-bus CPU control path: opcodes, IR field
// positions, sequencer states and opcode classification helpers.
package cpu_defs_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        T0   = 4'd1,
        T1   = 4'd2,
        T2   = 4'd3,
        T3   = 4'd4,
        T4   = 4'd5,
        T5   = 4'd6,
        T6   = 4'd7,
        HALT = 4'd8
    } state_t;

    // Two-operand instructions that take the Y/T4 path (includes MUL/DIV).
    function automatic logic is_binary(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA,
            OP_SHL, OP_ROR, OP_ROL, OP_MUL, OP_DIV: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    function automatic logic is_unary(input logic [4:0] op);
        case (op)
            OP_NEG, OP_NOT: return 1'b1;
            default:        return 1'b0;
        endcase
    endfunction

    function automatic logic is_muldiv(input logic [4:0] op);
        case (op)
            OP_MUL, OP_DIV: return 1'b1;
            default:        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/reg_decoder_4_to_16.sv
// One-hot register select decoder; all-zero output when disabled.
module reg_decoder_4_to_16 #(
    parameter int NUM_REGS = 16
) (
    input  logic [3:0]          field,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot
);

    // Decode the register field into a single select bit.
    always_comb begin
        onehot = '0;
        if (en && (int'(field) < NUM_REGS)) begin
            onehot[field] = 1'b1;
        end else begin
            onehot = '0;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit for the single-bus datapath: fetch with memory wait
// handshake, then execute steps for ALU, unary, mul/div, nop and halt.
module control_sequencer
    import cpu_defs_pkg::*;
#(
    parameter int NUM_REGS    = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [31:0]         ir,
    input  logic                mem_ready,
    output logic                PCout,
    output logic                MDRout,
    output logic                ZHighout,
    output logic                ZLowout,
    output logic                HIout,
    output logic                LOout,
    output logic                PCin,
    output logic                IncPC,
    output logic                MARin,
    output logic                MDRin,
    output logic                IRin,
    output logic                Yin,
    output logic                ZHighIn,
    output logic                ZLowIn,
    output logic                HIin,
    output logic                LOin,
    output logic                Read,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic [4:0]          operation,
    output logic                run,
    output logic                instr_done,
    output logic                err
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   wait_cnt_r, wait_cnt_s;
    logic               err_r, err_s;
    logic [4:0]         opcode_s;
    logic [3:0]         ra_s, rb_s, rc_s;
    logic               rin_en_s, rb_en_s, rc_en_s;
    logic [NUM_REGS-1:0] rout_b_s, rout_c_s;
    logic               unused_ir_s;

    assign opcode_s    = ir[OPC_MSB:OPC_LSB];
    assign ra_s        = ir[RA_MSB:RA_LSB];
    assign rb_s        = ir[RB_MSB:RB_LSB];
    assign rc_s        = ir[RC_MSB:RC_LSB];
    assign unused_ir_s = ^ir[RC_LSB-1:0];
    assign err         = err_r;

    // State, wait counter and sticky error registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r    <= IDLE;
            wait_cnt_r <= '0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
            err_r      <= err_s;
        end
    end

    // Next-state, wait counting and error detection.
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        err_s      = err_r;
        case (state_r)
            IDLE: state_s = T0;
            T0: begin
                state_s    = T1;
                wait_cnt_s = '0;
            end
            T1: begin
                // mem_ready takes priority over a coincident timeout
                if (mem_ready) begin
                    state_s    = T2;
                    wait_cnt_s = '0;
                end else if (wait_cnt_r == CNT_W'(MEM_TIMEOUT - 1)) begin
                    state_s    = HALT;
                    wait_cnt_s = '0;
                    err_s      = 1'b1;
                end else begin
                    wait_cnt_s = wait_cnt_r + CNT_W'(1);
                end
            end
            T2: state_s = T3;
            T3: begin
                if (is_binary(opcode_s)) begin
                    state_s = T4;
                end else if (is_unary(opcode_s)) begin
                    state_s = T5;
                end else if (opcode_s == OP_NOP) begin
                    state_s = T0;
                end else if (opcode_s == OP_HALT) begin
                    state_s = HALT;
                end else begin
                    state_s = T0;
                    err_s   = 1'b1;
                end
            end
            T4: state_s = T5;
            T5: begin
                if (is_muldiv(opcode_s)) begin
                    state_s = T6;
                end else begin
                    state_s = T0;
                end
            end
            T6:      state_s = T0;
            HALT:    state_s = HALT;
            default: state_s = IDLE;
        endcase
    end

    // Moore control decode of the state register and IR fields.
    always_comb begin
        {PCout, MDRout, ZHighout, ZLowout, HIout, LOout} = 6'b000000;
        {PCin, IncPC, MARin, MDRin, IRin, Yin}           = 6'b000000;
        {ZHighIn, ZLowIn, HIin, LOin, Read}              = 5'b00000;
        operation  = 5'b00000;
        run        = 1'b1;
        instr_done = 1'b0;
        rin_en_s   = 1'b0;
        rb_en_s    = 1'b0;
        rc_en_s    = 1'b0;
        case (state_r)
            T0: {PCout, MARin, IncPC} = 3'b111;
            T1: {Read, MDRin}         = 2'b11;
            T2: {MDRout, IRin}        = 2'b11;
            T3: begin
                if (is_binary(opcode_s)) begin
                    rb_en_s = 1'b1;
                    Yin     = 1'b1;
                end else if (is_unary(opcode_s)) begin
                    rb_en_s   = 1'b1;
                    operation = opcode_s;
                    ZLowIn    = 1'b1;
                end else begin
                    instr_done = 1'b1;
                end
            end
            T4: begin
                rc_en_s   = 1'b1;
                operation = opcode_s;
                ZLowIn    = 1'b1;
                ZHighIn   = 1'b1;
            end
            T5: begin
                ZLowout = 1'b1;
                if (is_muldiv(opcode_s)) begin
                    LOin = 1'b1;
                end else begin
                    // R0 is write-protected
                    rin_en_s   = (ra_s != 4'd0);
                    instr_done = 1'b1;
                end
            end
            T6: begin
                ZHighout   = 1'b1;
                HIin       = 1'b1;
                instr_done = 1'b1;
            end
            IDLE:    run = 1'b0;
            HALT:    run = 1'b0;
            default: run = 1'b0;
        endcase
    end

    reg_decoder_4_to_16 #(.NUM_REGS(NUM_REGS)) u_dec_rin (
        .field (ra_s),
        .en    (rin_en_s),
        .onehot(Rin)
    );

    reg_decoder_4_to_16 #(.NUM_REGS(NUM_REGS)) u_dec_rb (
        .field (rb_s),
        .en    (rb_en_s),
        .onehot(rout_b_s)
    );

    reg_decoder_4_to_16 #(.NUM_REGS(NUM_REGS)) u_dec_rc (
        .field (rc_s),
        .en    (rc_en_s),
        .onehot(rout_c_s)
    );

    assign Rout = rout_b_s | rout_c_s;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer.
module tb_control_sequencer;
    import cpu_defs_pkg::*;

    logic        clk, clr, mem_ready;
    logic [31:0] ir;
    logic        PCout, MDRout, ZHighout, ZLowout, HIout, LOout;
    logic        PCin, IncPC, MARin, MDRin, IRin, Yin, ZHighIn, ZLowIn, HIin, LOin, Read;
    logic [15:0] Rin, Rout;
    logic [4:0]  operation;
    logic        run, instr_done, err;
    logic [16:0] strb;

    int total = 0;
    int bad   = 0;

    // Strobe patterns, bit order matches strb below.
    localparam logic [31:0] S_NONE = 32'h00000;
    localparam logic [31:0] S_T0   = 32'h10300;
    localparam logic [31:0] S_T1   = 32'h00081;
    localparam logic [31:0] S_T2   = 32'h08040;
    localparam logic [31:0] S_YIN  = 32'h00020;
    localparam logic [31:0] S_ZLI  = 32'h00008;
    localparam logic [31:0] S_T4   = 32'h00018;
    localparam logic [31:0] S_T5A  = 32'h02000;
    localparam logic [31:0] S_T5M  = 32'h02002;
    localparam logic [31:0] S_T6   = 32'h04004;

    assign strb = {PCout, MDRout, ZHighout, ZLowout, HIout, LOout, PCin, IncPC,
                   MARin, MDRin, IRin, Yin, ZHighIn, ZLowIn, HIin, LOin, Read};

    control_sequencer #(.NUM_REGS(16), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .clr(clr), .ir(ir), .mem_ready(mem_ready),
        .PCout(PCout), .MDRout(MDRout), .ZHighout(ZHighout), .ZLowout(ZLowout),
        .HIout(HIout), .LOout(LOout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
        .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn),
        .HIin(HIin), .LOin(LOin), .Read(Read), .Rin(Rin), .Rout(Rout),
        .operation(operation), .run(run), .instr_done(instr_done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'b0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [31:0] s, input logic [31:0] rin_e,
                             input logic [31:0] rout_e, input logic [31:0] op_e,
                             input logic run_e, input logic done_e, input logic err_e);
        chk({tag, ".strobes"}, {15'b0, strb}, s);
        chk({tag, ".Rin"}, {16'b0, Rin}, rin_e);
        chk({tag, ".Rout"}, {16'b0, Rout}, rout_e);
        chk({tag, ".operation"}, {27'b0, operation}, op_e);
        chk({tag, ".run"}, {31'b0, run}, {31'b0, run_e});
        chk({tag, ".instr_done"}, {31'b0, instr_done}, {31'b0, done_e});
        chk({tag, ".err"}, {31'b0, err}, {31'b0, err_e});
    endtask

    // Checks T0, T1, T2 with mem_ready high, leaving the sequencer in T3.
    task automatic fetch(input string tag, input logic err_e);
        chk_state({tag, ".T0"}, S_T0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, err_e);
        step();
        chk_state({tag, ".T1"}, S_T1, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, err_e);
        step();
        chk_state({tag, ".T2"}, S_T2, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, err_e);
        step();
    endtask

    initial begin
        clr       = 1'b0;
        mem_ready = 1'b1;
        ir        = 32'h18A20000;
        step();
        step();
        chk_state("reset", S_NONE, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        clr = 1'b1;
        step();

        // ADD R1 <- R4 + R4
        fetch("add", 1'b0);
        chk_state("add.T3", S_YIN, 32'h0, 32'h0010, 32'h0, 1'b1, 1'b0, 1'b0);
        step();
        chk_state("add.T4", S_T4, 32'h0, 32'h0010, 32'h03, 1'b1, 1'b0, 1'b0);
        step();
        chk_state("add.T5", S_T5A, 32'h0002, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        step();

        // MUL Rb=3 Rc=1
        ir = mk_ir(OP_MUL, 4'd2, 4'd3, 4'd1);
        fetch("mul", 1'b0);
        chk_state("mul.T3", S_YIN, 32'h0, 32'h0008, 32'h0, 1'b1, 1'b0, 1'b0);
        step();
        chk_state("mul.T4", S_T4, 32'h0, 32'h0002, 32'h0F, 1'b1, 1'b0, 1'b0);
        step();
        chk_state("mul.T5", S_T5M, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        step();
        chk_state("mul.T6", S_T6, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        step();

        // NOP with a 3-cycle memory wait
        ir = mk_ir(OP_NOP, 4'd0, 4'd0, 4'd0);
        chk_state("wait.T0", S_T0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        mem_ready = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            chk_state("wait.T1", S_T1, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
            step();
        end
        mem_ready = 1'b1;
        chk_state("wait.T1last", S_T1, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        step();
        chk_state("wait.T2", S_T2, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        step();
        chk_state("nop.T3", S_NONE, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        step();

        // Memory timeout into HALT
        chk_state("to.T0", S_T0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        mem_ready = 1'b0;
        step();
        for (int i = 0; i < 15; i++) begin
            chk_state("to.T1", S_T1, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
            step();
        end
        for (int i = 0; i < 5; i++) begin
            chk_state("to.HALT", S_NONE, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
            step();
        end

        // Reset clears err
        clr = 1'b0;
        #1;
        chk_state("reset2", S_NONE, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        mem_ready = 1'b1;
        step();
        clr = 1'b1;
        step();

        // Illegal opcode behaves as NOP and sets err
        ir = mk_ir(5'b11111, 4'd1, 4'd1, 4'd1);
        fetch("ill", 1'b0);
        chk_state("ill.T3", S_NONE, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        step();

        // ADD with Ra=0: no register write
        ir = mk_ir(OP_ADD, 4'd0, 4'd2, 4'd5);
        fetch("r0", 1'b1);
        chk_state("r0.T3", S_YIN, 32'h0, 32'h0004, 32'h0, 1'b1, 1'b0, 1'b1);
        step();
        chk_state("r0.T4", S_T4, 32'h0, 32'h0020, 32'h03, 1'b1, 1'b0, 1'b1);
        step();
        chk_state("r0.T5", S_T5A, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
        step();

        // NOT R3 <- ~R7 skips T4
        ir = mk_ir(OP_NOT, 4'd3, 4'd7, 4'd0);
        fetch("not", 1'b1);
        chk_state("not.T3", S_ZLI, 32'h0, 32'h0080, 32'h12, 1'b1, 1'b0, 1'b1);
        step();
        chk_state("not.T5", S_T5A, 32'h0008, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
        step();

        // DIV aborted by reset during T4
        ir = mk_ir(OP_DIV, 4'd1, 4'd2, 4'd3);
        fetch("div", 1'b1);
        chk_state("div.T3", S_YIN, 32'h0, 32'h0004, 32'h0, 1'b1, 1'b0, 1'b1);
        step();
        chk_state("div.T4", S_T4, 32'h0, 32'h0008, 32'h10, 1'b1, 1'b0, 1'b1);
        clr = 1'b0;
        #1;
        chk_state("abort.async", S_NONE, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        ir = mk_ir(OP_NOP, 4'd0, 4'd0, 4'd0);
        step();
        chk_state("abort.held", S_NONE, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        clr = 1'b1;
        step();
        fetch("post", 1'b0);
        chk_state("post.T3", S_NONE, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        step();

        // HALT instruction parks the sequencer
        ir = mk_ir(OP_HALT, 4'd0, 4'd0, 4'd0);
        fetch("halt", 1'b0);
        chk_state("halt.T3", S_NONE, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        step();
        for (int i = 0; i < 20; i++) begin
            chk_state("halt.hold", S_NONE, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that drives every control input of the single-bus CPU datapath: register in/out strobes, PC/MAR/MDR/IR/Y/Z/HI/LO enables, the 5-bit ALU operation and the memory Read strobe.
- Sits directly upstream of the datapath and consumes the IR contents the datapath produces.
- Sequences instruction fetch (with a memory wait handshake), then the execute step for register-register ALU, unary, mul/div, nop and halt instructions.

Parameters:
- NUM_REGS, 16, number of general registers; width of the one-hot Rin/Rout vectors.
- MEM_TIMEOUT, 15, maximum wait cycles in the fetch-read state before a bus error.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  asynchronous, active-low reset.
- ir  in  32  current IR register contents; opcode ir[31:27], Ra ir[26:23], Rb ir[22:19], Rc ir[18:15].
- mem_ready  in  1  memory has placed valid data on MDatain.
- PCout, MDRout, ZHighout, ZLowout, HIout, LOout  out  1 each  bus-drive strobes.
- PCin, IncPC, MARin, MDRin, IRin, Yin, ZHighIn, ZLowIn, HIin, LOin, Read  out  1 each  load/enable strobes.
- Rin  out  NUM_REGS  one-hot register load.
- Rout  out  NUM_REGS  one-hot register drive.
- operation  out  5  ALU opcode.
- run  out  1  high while the sequencer is executing; low in IDLE and HALT.
- instr_done  out  1  one-cycle pulse on the final execute step of each instruction.
- err  out  1  sticky error flag (illegal opcode or memory timeout).

Behaviour:
- Outputs are a Moore decode of the state register, plus ir fields in states T3..T6. They are glitch-free relative to clk.
- Reset (clr=0, asynchronous): state=IDLE. All outputs 0, including err and the wait counter.
- IDLE -> T0 on the first rising edge after clr deasserts.
- T0: PCout, MARin, IncPC. Next state is T1.
- T1: Read, MDRin. Stay in T1 while mem_ready=0 and incrementing the wait counter.
  - mem_ready=1 -> T2 and the counter clears.
  - Counter reaches MEM_TIMEOUT with mem_ready still 0 -> set err, go to HALT.
  - mem_ready=1 on the same edge as the timeout -> mem_ready wins.
- T2: MDRout, IRin. Next state is T3. IR is valid from T3 onward.
- T3 decode on ir[31:27]:
  - Binary ALU (ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL), MUL, DIV: Rout[Rb], Yin; next T4.
  - Unary (NEG, NOT): Rout[Rb], operation=opcode, ZLowIn; next T5.
  - NOP: instr_done; next T0.
  - HALT: instr_done; next HALT.
  - Any other opcode: set err, instr_done; next T0. The opcode is treated as a NOP.
- T4: Rout[Rc], operation=opcode, ZLowIn and ZHighIn. Next T5.
- T5:
  - ALU/unary: ZLowout, Rin[Ra], instr_done; next T0.
  - MUL/DIV: ZLowout, LOin; next T6.
- T6 (MUL/DIV only): ZHighout, HIin, instr_done; next T0.
- Ra=0: Rin stays all-zero because R0 is write-protected. instr_done still pulses.
- Rout/Rin are exactly one-hot or all-zero. At most one *out strobe or Rout bit is high in any cycle.
- operation=0 in every state that does not use the ALU.
- HALT: all strobes 0, run=0. Exit only via clr.
- err clears only on reset.
- clr asserted mid-instruction aborts immediately to IDLE. No partial writes are issued after the reset edge.

Decomposition:
- Shared package cpu_defs_pkg holds:
  - opcode constants: ADD=00011, SUB=00100, AND=00101, OR=00110, SHR=00111, SHRA=01000, SHL=01001, ROR=01010, ROL=01011, MUL=01111, DIV=10000, NEG=10001, NOT=10010, NOP=11010, HALT=11011;
  - the IR field bit positions;
  - the state enum (IDLE, T0..T6, HALT).
- One sub-module, reg_decoder_4_to_16: 4-bit field plus enable in, one-hot NUM_REGS out. Instantiated for Rin[Ra], Rout[Rb] and Rout[Rc].

Test Plan:
- Reset/fetch: clr low 2 cycles, then release with mem_ready tied 1 -> IDLE, then T0 (PCout=MARin=IncPC=1), T1 (Read=MDRin=1), T2 (MDRout=IRin=1). run=1 from T0.
- ADD: ir=0x18A20000 (opcode ADD, Ra=1, Rb=4, Rc=4) -> T3 Rout=0x0010 + Yin; T4 Rout=0x0010, operation=00011, ZLowIn; T5 ZLowout, Rin=0x0002, instr_done pulse; back to T0.
- MUL: opcode 01111, Rb=3, Rc=1 -> T4 ZHighIn=ZLowIn=1; T5 ZLowout+LOin; T6 ZHighout+HIin+instr_done. Total 7 cycles from T0.
- Wait/timeout: mem_ready=0 for 3 cycles, then 1 -> T1 lasts 4 cycles, err stays 0. mem_ready held 0 -> after 15 wait cycles err=1, state HALT, run=0, all strobes 0.
- Illegal/R0: opcode 11111 -> err=1, instr_done, next fetch proceeds. ADD with Ra=0 -> Rin stays 0x0000 in T5.
- HALT and mid-op reset: HALT opcode -> run=0 held for 20 cycles. clr pulsed low during T4 of a DIV -> outputs 0 asynchronously, and neither LOin nor HIin ever asserts.
